// File: rtl/mux_rr_reg.sv
// Registered N-way W-bit channel selector with valid/ready on every input and the output.
// Selection is either directed by s or round-robin among valid channels.
module mux_rr_reg #(
    parameter int N = 5,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0][W-1:0] d,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic                mode,
    input  logic [SW-1:0]       s,
    output logic [W-1:0]        out_data,
    output logic [SW-1:0]       out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [SW-1:0] ptr_reg;
    logic [SW-1:0] gidx;
    logic [SW-1:0] cand;
    logic [N-1:0]  grant;
    logic          grant_any;
    logic          can_accept;
    logic          load;
    int            idx;

    assign can_accept = !out_valid || out_ready;
    assign load       = grant_any && can_accept;

    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        cand      = '0;
        idx       = 0;
        if (!mode) begin
            // Codes N..2^SW-1 select nothing.
            if (({1'b0, s} < (SW+1)'(N)) && in_valid[s]) begin
                grant_any = 1'b1;
                gidx      = s;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = int'(ptr_reg) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                cand = SW'(idx);
                if (!grant_any && in_valid[cand]) begin
                    grant_any = 1'b1;
                    gidx      = cand;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign grant[gi]    = grant_any && (gidx == SW'(gi));
            assign in_ready[gi] = grant[gi] && can_accept && !reset;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_reg   <= SW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= d[gidx];
            out_ch    <= gidx;
            if (mode) begin
                ptr_reg <= gidx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised, registered N-way, W-bit channel selector with valid/ready handshakes on every input and on the output. It is the successor to the fixed 5:1 single-bit combinational mux. It adds two selection modes: directed (external select, out-of-range selects nothing) and round-robin arbitration among valid channels. It sits between multiple producers (e.g. register-file read ports, immediate sources) and a single registered consumer stage in the datapath.

## Interface
- N, default 5: number of input channels, N ≥ 2.
- W, default 8: data width per channel, W ≥ 1.
- SW, derived as $clog2(N), not overridable: width of select and channel-ID fields.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- d  input  N×W  packed array d[N-1:0][W-1:0]; channel i data.
- in_valid  input  N  channel i has data.
- in_ready  output  N  channel i is transferred this cycle when in_valid[i] & in_ready[i].
- mode  input  1  0 = directed, 1 = round-robin.
- s  input  SW  directed-mode channel select.
- out_data  output  W  registered selected data.
- out_ch  output  SW  channel index that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- One-entry output register (data, ch, valid).
- can_accept = !out_valid | out_ready.
- grant is a one-hot N-bit value, or all-zero. Only the granted channel sees in_ready[i] = grant[i] & can_accept. All other in_ready bits are 0.
- Directed mode (mode=0):
  - grant = onehot(s) gated by in_valid[s].
  - s ≥ N grants nothing: all in_ready = 0 and no load occurs. This is the "out of range → 0" rule carried forward.
- Round-robin mode (mode=1):
  - Priority pointer ptr (SW bits) holds the last channel that transferred in RR mode.
  - The search starts at ptr+1 and wraps modulo N (ptr = N-1 wraps to 0). The first channel with in_valid set is granted.
  - No valid channel means grant = 0.
- Transfer: when grant ≠ 0 and can_accept, on the next edge:
  - out_data ← d[g], out_ch ← g, out_valid ← 1.
  - In RR mode only, ptr ← g.
- Drain without load: out_valid & out_ready & no transfer clears out_valid. out_data and out_ch hold their old values.
- Stall: out_valid & !out_ready holds out_data, out_ch and out_valid stable. All in_ready = 0.
- Simultaneous drain and load in one cycle: the new entry replaces the old one and out_valid stays 1.
- Mode switch: takes effect in the same cycle, because selection is combinational on mode. ptr is retained across directed-mode periods and is not updated by directed transfers.
- Width rule: the data path is pure selection, with no truncation or extension. Unused select codes N..2^SW-1 behave as in directed mode with s ≥ N.

## Timing
- Reset (async assert, synchronous release at the next edge):
  - out_valid=0, out_data=0, out_ch=0, ptr=N-1, so channel 0 has first RR priority.
  - in_ready=0 while reset is asserted.
- Reset mid-transfer: any held output is discarded. A handshake in the cycle reset asserts is not completed.
- Latency: 1 cycle from input handshake edge to out_valid=1 with the data.
- Throughput: 1 transfer per cycle while out_ready=1 and any grant exists.
- in_ready is combinational from in_valid, mode, s, out_ready and registered state. The producer must not make in_valid depend on in_ready.
- out_* are driven only from flops. There is no combinational path from any input to out_data, out_ch or out_valid.
- A producer must hold d[i] and in_valid[i] stable until its handshake completes. The block does not enforce this.

## Test plan
- Reset, then directed with N=5, W=8: s=2, d[2]=8'hA5, in_valid=5'b00100, out_ready=1 → in_ready=5'b00100. Next cycle out_valid=1, out_data=A5, out_ch=2.
- Directed out of range: s=5 and s=7 with in_valid=5'b11111 → in_ready=0 and out_valid stays 0 for 4 cycles.
- Round-robin fairness: mode=1, in_valid=5'b11111 held, out_ready=1, d[i]=8'h10+i → out_ch sequence 0,1,2,3,4,0,1 on consecutive cycles. Then drop in_valid to 5'b10010 → grants alternate 4,1,4,1.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles → out_data and out_ch are unchanged and in_ready=0. Raising out_ready in the same cycle as a new grant → new data appears the next cycle with out_valid continuously 1.
- Mode interleave: in RR, grant ch3; switch to directed and transfer s=0 twice; switch back to RR with all valid → next grant is ch4 (pointer retained at 3).
- Async reset mid-stream: assert reset between edges while out_valid=1 and a stall is in progress → out_valid=0 immediately. After release with all valid in RR, the first grant is ch0.
